// File: rtl/panel_pkg.sv
// panel_pkg: state encoding and default display patterns shared by the panel sequencer
package panel_pkg;
  typedef enum logic [1:0] {
    ST_IDLE     = 2'b00,
    ST_DATA_IN  = 2'b01,
    ST_WORK     = 2'b10,
    ST_DATA_OUT = 2'b11
  } state_t;
  localparam logic [15:0] IDLE_PAT_DEF = 16'hABCD;
  localparam logic [15:0] WORK_PAT_DEF = 16'hEEEE;
endpackage

// File: rtl/btn_conditioner.sv
// btn_conditioner: synchronise, debounce and edge-detect one raw push button
module btn_conditioner #(
  parameter int unsigned DEB_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic press
);
  localparam int CW = $clog2(DEB_CYCLES + 1);
  logic [1:0] sync;
  logic [CW-1:0] cnt;
  logic level_d;
  logic done;
  assign done = cnt == CW'(DEB_CYCLES - 1);
  always_ff @(posedge clk) begin
    if (rst) begin
      sync    <= '0;
      cnt     <= '0;
      level   <= 1'b0;
      level_d <= 1'b0;
      press   <= 1'b0;
    end else begin
      sync    <= {sync[0], raw};
      level_d <= level;
      press   <= level & ~level_d;
      cnt     <= (sync[1] == level || done) ? '0 : cnt + 1'b1;
      if (sync[1] != level && done) level <= sync[1];
    end
  end
endmodule

// File: rtl/panel_mode_seq.sv
// panel_mode_seq: front-panel mode FSM (IDLE/DATA_IN/WORK/DATA_OUT) with
// debounced buttons, registered display mux and saturating browse address.
module panel_mode_seq
  import panel_pkg::*;
#(
  parameter int                DATA_W     = 16,
  parameter int                ADDR_W     = 32,
  parameter logic [ADDR_W-1:0] ADDR_STEP  = 4,
  parameter logic [ADDR_W-1:0] ADDR_MAX   = 32'h3FC,
  parameter logic [DATA_W-1:0] IDLE_PAT   = IDLE_PAT_DEF,
  parameter logic [DATA_W-1:0] WORK_PAT   = WORK_PAT_DEF,
  parameter int unsigned       DEB_CYCLES = 1_000_000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              button,
  input  logic              u_button,
  input  logic              d_button,
  input  logic              work_done,
  input  logic [DATA_W-1:0] pre_data,
  input  logic [DATA_W-1:0] fin_data,
  output logic [DATA_W-1:0] data,
  output logic              work_ena,
  output logic              ce,
  output logic [ADDR_W-1:0] addr,
  output logic [1:0]        mode
);
  logic mode_p, up_p, dn_p, adv;
  logic [2:0] unused_level;
  state_t state, nxt;
  logic [DATA_W-1:0] data_nxt;
  logic [ADDR_W-1:0] addr_nxt;
  logic [ADDR_W:0] up_sum;
  btn_conditioner #(.DEB_CYCLES(DEB_CYCLES)) u_mode (
    .clk, .rst, .raw(button), .level(unused_level[0]), .press(mode_p)
  );
  btn_conditioner #(.DEB_CYCLES(DEB_CYCLES)) u_up (
    .clk, .rst, .raw(u_button), .level(unused_level[1]), .press(up_p)
  );
  btn_conditioner #(.DEB_CYCLES(DEB_CYCLES)) u_dn (
    .clk, .rst, .raw(d_button), .level(unused_level[2]), .press(dn_p)
  );
  // one extra bit so the top-of-range sum cannot wrap below ADDR_MAX
  assign up_sum = {1'b0, addr} + {1'b0, ADDR_STEP};
  always_comb begin
    adv      = mode_p | ((state == ST_WORK) & work_done);
    nxt      = adv ? state_t'(state + 2'd1) : state;
    data_nxt = nxt == ST_IDLE ? IDLE_PAT : nxt == ST_DATA_IN ? pre_data :
               nxt == ST_WORK ? WORK_PAT : fin_data;
    addr_nxt = addr;
    if (state != ST_DATA_OUT || mode_p) addr_nxt = '0;
    else if (up_p & ~dn_p & (up_sum <= {1'b0, ADDR_MAX})) addr_nxt = up_sum[ADDR_W-1:0];
    else if (dn_p & ~up_p & (addr >= ADDR_STEP)) addr_nxt = addr - ADDR_STEP;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      data     <= IDLE_PAT;
      work_ena <= 1'b0;
      ce       <= 1'b0;
      addr     <= '0;
    end else begin
      state    <= nxt;
      data     <= data_nxt;
      work_ena <= nxt == ST_WORK;
      ce       <= nxt == ST_DATA_OUT;
      addr     <= addr_nxt;
    end
  end
  assign mode = state;
endmodule

// File: tb/tb_panel_mode_seq.sv
// tb_panel_mode_seq: directed scenarios plus random button traffic checked every cycle
// against a window-based behavioural model of debounce, FSM and browse address.
module tb_panel_mode_seq;
  localparam int DEB = 4;
  localparam logic [31:0] STEP = 4;
  localparam logic [31:0] AMAX = 12;
  localparam logic [15:0] IPAT = 16'hABCD;
  localparam logic [15:0] WPAT = 16'hEEEE;
  logic clk = 0, rst = 1, button = 0, u_button = 0, d_button = 0, work_done = 0;
  logic [15:0] pre_data = 0, fin_data = 0;
  logic [15:0] data;
  logic work_ena, ce;
  logic [31:0] addr;
  logic [1:0] mode;
  int checks = 0, errors = 0;
  bit chk_en = 0;
  always #5 clk = ~clk;
  panel_mode_seq #(
    .DATA_W(16), .ADDR_W(32), .ADDR_STEP(STEP), .ADDR_MAX(AMAX),
    .IDLE_PAT(IPAT), .WORK_PAT(WPAT), .DEB_CYCLES(DEB)
  ) dut (
    .clk(clk), .rst(rst), .button(button), .u_button(u_button), .d_button(d_button),
    .work_done(work_done), .pre_data(pre_data), .fin_data(fin_data),
    .data(data), .work_ena(work_ena), .ce(ce), .addr(addr), .mode(mode)
  );
  // model: a button level flips once the last DEB synchronised samples all disagree with it
  int m_state;
  logic [15:0] m_data;
  logic [31:0] m_addr;
  bit rq[3][$];
  bit win[3][$];
  bit lvl[3], lvl_d[3], prs[3];
  always @(posedge clk) begin
    bit raw[3];
    bit adv;
    int n;
    raw = '{button, u_button, d_button};
    if (rst) begin
      m_state = 0; m_data = IPAT; m_addr = 0;
      for (int b = 0; b < 3; b++) begin
        rq[b] = '{1'b0, 1'b0};
        win[b] = {};
        for (int j = 0; j < DEB; j++) win[b].push_back(1'b0);
        lvl[b] = 0; lvl_d[b] = 0; prs[b] = 0;
      end
    end else begin
      adv = prs[0] || (m_state == 2 && work_done);
      if (m_state == 3) begin
        if (prs[0]) m_addr = 0;
        else if (prs[1] && !prs[2] && m_addr + STEP <= AMAX) m_addr = m_addr + STEP;
        else if (prs[2] && !prs[1] && m_addr >= STEP) m_addr = m_addr - STEP;
      end
      if (adv) m_state = (m_state + 1) % 4;
      m_data = m_state == 0 ? IPAT : m_state == 1 ? pre_data : m_state == 2 ? WPAT : fin_data;
      for (int b = 0; b < 3; b++) begin
        win[b].push_front(rq[b][1]);
        void'(win[b].pop_back());
        prs[b] = lvl[b] && !lvl_d[b];
        lvl_d[b] = lvl[b];
        n = 0;
        for (int j = 0; j < DEB; j++) if (win[b][j] != lvl[b]) n++;
        if (n == DEB) lvl[b] = !lvl[b];
        rq[b].push_front(raw[b]);
        void'(rq[b].pop_back());
      end
    end
  end
  always @(negedge clk) begin
    if (chk_en) begin
      checks++;
      if ({data, work_ena, ce, addr, mode} !==
          {m_data, m_state == 2, m_state == 3, m_addr, 2'(m_state)}) begin
        errors++;
        $display("FAIL cycle_model t=%0t: data=%h/%h wena=%b/%b ce=%b/%b addr=%0d/%0d mode=%0d/%0d (got/exp)",
                 $time, data, m_data, work_ena, m_state == 2, ce, m_state == 3, addr, m_addr, mode, m_state);
      end
    end
  end
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic press(input bit m, input bit u, input bit d);
    button = m; u_button = u; d_button = d;
    tick(10);
    button = 0; u_button = 0; d_button = 0;
    tick(10);
  endtask
  initial begin
    int ups[5] = '{4, 8, 12, 12, 12};
    int dns[4] = '{8, 4, 0, 0};
    tick(2);
    chk_en = 1;
    rst = 0;
    chk("reset_mode", 32'(mode), 0);
    chk("reset_data", 32'(data), 32'hABCD);
    chk("reset_addr", addr, 0);
    pre_data = 16'h1234; fin_data = 16'h5678;
    press(1, 0, 0);
    chk("loop_mode1", 32'(mode), 1);
    chk("loop_data1", 32'(data), 32'h1234);
    press(1, 0, 0);
    chk("loop_mode2", 32'(mode), 2);
    chk("loop_data2", 32'(data), 32'hEEEE);
    chk("loop_wena2", 32'(work_ena), 1);
    press(1, 0, 0);
    chk("loop_mode3", 32'(mode), 3);
    chk("loop_data3", 32'(data), 32'h5678);
    chk("loop_ce3", 32'(ce), 1);
    press(1, 0, 0);
    chk("loop_mode0", 32'(mode), 0);
    chk("loop_data0", 32'(data), 32'hABCD);
    repeat (2) begin
      button = 1; tick(3); button = 0; tick(3);
    end
    button = 1; tick(100); button = 0; tick(10);
    chk("bounce_one_step", 32'(mode), 1);
    press(1, 0, 0);
    chk("pre_reset_work", 32'(mode), 2);
    rst = 1; tick(1); rst = 0;
    chk("rst_work_mode", 32'(mode), 0);
    chk("rst_work_data", 32'(data), 32'hABCD);
    chk("rst_work_wena", 32'(work_ena), 0);
    repeat (3) press(1, 0, 0);
    foreach (ups[i]) begin
      press(0, 1, 0);
      chk($sformatf("browse_up%0d", i), addr, ups[i]);
    end
    foreach (dns[i]) begin
      press(0, 0, 1);
      chk($sformatf("browse_dn%0d", i), addr, dns[i]);
    end
    press(1, 0, 0);
    press(0, 1, 0);
    chk("up_in_idle_mode", 32'(mode), 0);
    chk("up_in_idle_addr", addr, 0);
    repeat (3) press(1, 0, 0);
    press(0, 1, 0);
    chk("sim_pre_addr", addr, 4);
    press(0, 1, 1);
    chk("sim_updown_addr", addr, 4);
    press(1, 1, 0);
    chk("sim_modeup_mode", 32'(mode), 0);
    chk("sim_modeup_addr", addr, 0);
    repeat (2) press(1, 0, 0);
    work_done = 1; tick(1); work_done = 0;
    chk("autofinish_mode", 32'(mode), 3);
    press(1, 0, 0);
    work_done = 1; tick(1); work_done = 0; tick(2);
    chk("done_in_idle", 32'(mode), 0);
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(5) == 0) button = ~button;
      if ($urandom_range(4) == 0) u_button = ~u_button;
      if ($urandom_range(6) == 0) d_button = ~d_button;
      work_done = $urandom_range(19) == 0;
      pre_data = 16'($urandom);
      fin_data = 16'($urandom);
      rst = $urandom_range(399) == 0;
      tick(1);
    end
    rst = 0;
    tick(2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
